// File: rtl/fsa_col_reader.sv
// fsa_col_reader: reads one window of FSA column records back
// from a record bank and streams them out over AXI4-Stream.
module fsa_col_reader #(
  parameter int C_IMG_HW = 12,
  parameter int C_IMG_WW = 12,
  parameter int BR_NUM   = 4,
  parameter int BR_AW    = 12,
  localparam int REC_W   = 3 + 4 * C_IMG_HW,
  localparam int BI_W    = (BR_NUM > 1) ? $clog2(BR_NUM) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BR_NUM-1:0]       bank_sel,
  input  logic [C_IMG_WW-1:0]     win_left,
  input  logic [C_IMG_WW-1:0]     win_width,
  output logic [BR_NUM-1:0]       rd_en,
  output logic [BR_AW-1:0]        rd_addr,
  input  logic [BR_NUM*REC_W-1:0] rd_data,
  output logic                    m_axis_tvalid,
  output logic [REC_W-1:0]        m_axis_tdata,
  output logic                    m_axis_tuser,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [BI_W-1:0]     bank_q;
  logic [BR_AW-1:0]    base_q;
  logic [C_IMG_WW-1:0] width_q;
  logic [C_IMG_WW-1:0] cnt_q;
  logic [BR_AW-1:0]    addr_q;
  logic                infl_q;
  logic                infl_first_q;
  logic                infl_last_q;
  logic [REC_W+1:0]    mem_q [2];
  logic                wr_q;
  logic                rd_q;
  logic [1:0]          fill_q;
  logic                ovr_q;

  logic [BI_W-1:0]  sel_idx;
  logic             pop;
  logic [2:0]       occ;
  logic             issue;
  logic             last_issue;
  logic [BR_AW-1:0] next_addr;
  logic [REC_W-1:0] rec_sel;
  logic [REC_W+1:0] head;

  // lowest set bit wins; an empty select falls back to bank 0
  always_comb begin
    sel_idx = '0;
    for (int k = BR_NUM - 1; k >= 0; k--)
      if (bank_sel[k]) sel_idx = BI_W'(k);
  end

  // a read may only issue if its beat is guaranteed a FIFO slot
  always_comb begin
    pop        = (fill_q != 2'd0) && m_axis_tready;
    occ        = 3'(fill_q) + 3'(infl_q) - 3'(pop);
    issue      = (state_q == READ) && (occ < 3'd2);
    last_issue = issue &&
                 (cnt_q == width_q - C_IMG_WW'(1));
    next_addr  = base_q + BR_AW'(cnt_q);
    rec_sel    = rd_data[int'(bank_q)*REC_W +: REC_W];
    head       = mem_q[rd_q];
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start)
          state_d = (win_width == '0) ? DRAIN : READ;
      end
      READ: begin
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if (fill_q == 2'd0 && !infl_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bank_q       <= '0;
      base_q       <= '0;
      width_q      <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      infl_q       <= 1'b0;
      infl_first_q <= 1'b0;
      infl_last_q  <= 1'b0;
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      fill_q       <= 2'd0;
      ovr_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      ovr_q   <= start && (state_q != IDLE);
      if (state_q == IDLE && start) begin
        bank_q  <= sel_idx;
        base_q  <= BR_AW'(win_left);
        width_q <= win_width;
        cnt_q   <= '0;
      end
      if (issue) begin
        cnt_q  <= cnt_q + C_IMG_WW'(1);
        addr_q <= next_addr;
      end
      infl_q       <= issue;
      infl_first_q <= issue && (cnt_q == '0);
      infl_last_q  <= last_issue;
      if (infl_q) begin
        mem_q[wr_q] <= {infl_last_q, infl_first_q,
                        rec_sel};
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      fill_q <= fill_q + 2'(infl_q) - 2'(pop);
    end
  end

  always_comb begin
    rd_en         = issue ? (BR_NUM'(1) << bank_q) : '0;
    rd_addr       = issue ? next_addr : addr_q;
    m_axis_tvalid = (fill_q != 2'd0);
    m_axis_tdata  = m_axis_tvalid ? head[REC_W-1:0] : '0;
    m_axis_tuser  = m_axis_tvalid & head[REC_W];
    m_axis_tlast  = m_axis_tvalid & head[REC_W+1];
    busy          = (state_q != IDLE);
    overrun       = ovr_q;
  end

endmodule

// File: tb/tb_fsa_col_reader.sv
// tb_fsa_col_reader: directed frames against a queue model of the
// record stream, with a behavioural bank RAM behind the reader.
module tb_fsa_col_reader;
  localparam int HW = 12;
  localparam int WW = 12;
  localparam int NB = 4;
  localparam int AW = 12;
  localparam int RW = 3 + 4 * HW;

  typedef struct {
    logic [RW-1:0] d;
    logic          u;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [NB-1:0] bank_sel = '0;
  logic [WW-1:0] win_left = '0;
  logic [WW-1:0] win_width = '0;
  logic [NB-1:0] rd_en;
  logic [AW-1:0] rd_addr;
  logic [NB*RW-1:0] rd_data;
  logic tvalid, tuser, tlast;
  logic tready = 1'b1;
  logic [RW-1:0] tdata;
  logic busy, done, overrun;

  fsa_col_reader #(
    .C_IMG_HW(HW), .C_IMG_WW(WW),
    .BR_NUM(NB), .BR_AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .bank_sel(bank_sel), .win_left(win_left),
    .win_width(win_width), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .m_axis_tvalid(tvalid), .m_axis_tdata(tdata),
    .m_axis_tuser(tuser), .m_axis_tlast(tlast),
    .m_axis_tready(tready), .busy(busy),
    .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  beat_t exp_beat[$];
  int exp_addr[$];
  logic [NB-1:0] exp_en = '0;
  int issued = 0;
  int accepted = 0;
  bit done_seen = 0;
  int done_cyc = -1;
  int ovr_n = 0;
  int ovr_cyc = -1;
  int q_rd_cyc[$];
  int q_rd_addr[$];
  int q_bt_cyc[$];
  logic [RW-1:0] q_bt_d[$];
  logic q_bt_u[$];
  logic q_bt_l[$];
  logic [NB-1:0] en_n = '0;
  logic [AW-1:0] addr_n = '0;
  bit prev_stall = 0;
  logic [RW+2:0] prev_val = '0;
  int pat[4] = '{1, 0, 0, 1};
  bit use_pat = 0;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // bank k holds {k, address} at every address
  function automatic logic [RW-1:0] rec(input int k,
                                        input int a);
    logic [1:0]  kb;
    logic [11:0] ab;
    kb = 2'(k);
    ab = 12'(a);
    return {1'b0, kb, 36'd0, ab};
  endfunction

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int k = 0; k < NB; k++)
        rd_data[k*RW +: RW] <= rec(k, 4095);
    end else begin
      for (int k = 0; k < NB; k++)
        if (en_n[k])
          rd_data[k*RW +: RW] <= rec(k, int'(addr_n));
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    int a;
    beat_t b;
    en_n   = rd_en;
    addr_n = rd_addr;
    if (reset) begin
      chk("reset_ctl", 64'({rd_en, rd_addr, tvalid, tuser,
          tlast, busy, done, overrun}), 64'(0));
      chk("reset_tdata", 64'(tdata), 64'(0));
      prev_stall = 0;
    end else begin
      if (!busy)
        chk("idle_quiet", 64'({tvalid, rd_en}), 64'(0));
      if (rd_en != '0) begin
        issued++;
        q_rd_cyc.push_back(cyc - t0);
        q_rd_addr.push_back(int'(rd_addr));
        if (exp_addr.size() == 0)
          chk("rd_spurious", 64'(rd_en), 64'(0));
        else begin
          a = exp_addr.pop_front();
          chk("rd_en", 64'(rd_en), 64'(exp_en));
          chk("rd_addr", 64'(rd_addr), 64'(a));
        end
      end
      if (prev_stall)
        chk("hold", 64'({tvalid, tuser, tlast, tdata}),
            64'(prev_val));
      if (tvalid && tready) begin
        accepted++;
        q_bt_cyc.push_back(cyc - t0);
        q_bt_d.push_back(tdata);
        q_bt_u.push_back(tuser);
        q_bt_l.push_back(tlast);
        if (exp_beat.size() == 0)
          chk("beat_spurious", 64'(tvalid), 64'(0));
        else begin
          b = exp_beat.pop_front();
          chk("tdata", 64'(tdata), 64'(b.d));
          chk("tuser", 64'(tuser), 64'(b.u));
          chk("tlast", 64'(tlast), 64'(b.l));
        end
      end
      if (busy)
        chk("outstanding", 64'((issued - accepted) <= 2),
            64'(1));
      if (done) begin
        done_seen = 1;
        done_cyc  = cyc - t0;
        chk("done_flush",
            64'(exp_beat.size() + exp_addr.size()), 64'(0));
      end
      if (overrun) begin
        ovr_n++;
        ovr_cyc = cyc - t0;
      end
      prev_stall = tvalid && !tready;
      prev_val   = {tvalid, tuser, tlast, tdata};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    q_rd_cyc.delete();
    q_rd_addr.delete();
    q_bt_cyc.delete();
    q_bt_d.delete();
    q_bt_u.delete();
    q_bt_l.delete();
    issued    = 0;
    accepted  = 0;
    done_seen = 0;
    done_cyc  = -1;
    ovr_n     = 0;
    ovr_cyc   = -1;
  endtask

  task automatic model_frame(input logic [NB-1:0] sel,
                             input int left, input int w);
    int bk;
    bk = 0;
    for (int k = NB - 1; k >= 0; k--)
      if (sel[k]) bk = k;
    exp_en = 4'(1) << bk;
    for (int i = 0; i < w; i++) begin
      beat_t b;
      int a;
      a   = (left + i) % (1 << AW);
      b.d = rec(bk, a);
      b.u = (i == 0);
      b.l = (i == w - 1);
      exp_beat.push_back(b);
      exp_addr.push_back(a);
    end
  endtask

  task automatic launch(input logic [NB-1:0] sel,
                        input int left, input int w);
    clear_logs();
    model_frame(sel, left, w);
    bank_sel  = sel;
    win_left  = WW'(left);
    win_width = WW'(w);
    start     = 1'b1;
    t0        = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 300; n++) begin
      if (done_seen) break;
      if (use_pat) tready = (pat[(cyc - t0 + 1) % 4] != 0);
      tick();
    end
    chk("done_seen", 64'(done_seen), 64'(1));
  endtask

  task automatic run_frame(input logic [NB-1:0] sel,
                           input int left, input int w,
                           input int exp_done);
    launch(sel, left, w);
    wait_done();
    chk("busy_after", 64'(busy), 64'(0));
    if (exp_done >= 0)
      chk("done_cyc", 64'(done_cyc), 64'(exp_done));
    chk("beat_count", 64'(q_bt_cyc.size()), 64'(w));
    chk("read_count", 64'(q_rd_cyc.size()), 64'(w));
  endtask

  initial begin
    logic [RW-1:0] lit;
    logic [RW-1:0] dv;
    reset = 1'b0;
    #1 reset = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("idle_busy", 64'(busy), 64'(0));

    // basic frame, bank 2, full throughput
    run_frame(4'b0100, 10, 4, 7);
    for (int i = 0; i < 4; i++) begin
      chk("basic_rd_cyc", 64'(q_rd_cyc[i]), 64'(i + 1));
      chk("basic_rd_addr", 64'(q_rd_addr[i]), 64'(10 + i));
      chk("basic_bt_cyc", 64'(q_bt_cyc[i]), 64'(3 + i));
    end
    lit = {1'b0, 2'd2, 36'd0, 12'd10};
    chk("basic_d0", 64'(q_bt_d[0]), 64'(lit));
    lit = {1'b0, 2'd2, 36'd0, 12'd13};
    chk("basic_d3", 64'(q_bt_d[3]), 64'(lit));
    chk("basic_u0", 64'(q_bt_u[0]), 64'(1));
    chk("basic_l0", 64'(q_bt_l[0]), 64'(0));
    chk("basic_u3", 64'(q_bt_u[3]), 64'(0));
    chk("basic_l3", 64'(q_bt_l[3]), 64'(1));

    // backpressure with tready 1,0,0,1,...
    use_pat = 1;
    run_frame(4'b0001, 500, 8, -1);
    use_pat = 0;
    tready  = 1'b1;
    lit = {1'b0, 2'd0, 36'd0, 12'd507};
    chk("bp_d7", 64'(q_bt_d[7]), 64'(lit));

    // address wrap
    run_frame(4'b0100, 4094, 4, 7);
    chk("wrap_a0", 64'(q_rd_addr[0]), 64'(4094));
    chk("wrap_a1", 64'(q_rd_addr[1]), 64'(4095));
    chk("wrap_a2", 64'(q_rd_addr[2]), 64'(0));
    chk("wrap_a3", 64'(q_rd_addr[3]), 64'(1));

    // single column
    run_frame(4'b1000, 7, 1, 4);
    chk("w1_user", 64'(q_bt_u[0]), 64'(1));
    chk("w1_last", 64'(q_bt_l[0]), 64'(1));

    // empty window
    run_frame(4'b0001, 5, 0, 1);

    // overrun: second start two cycles in
    launch(4'b0001, 200, 6);
    tick();
    bank_sel  = 4'b1000;
    win_left  = WW'(300);
    win_width = WW'(3);
    start     = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    chk("ovr_count", 64'(ovr_n), 64'(1));
    chk("ovr_cyc", 64'(ovr_cyc), 64'(3));
    chk("ovr_beats", 64'(q_bt_cyc.size()), 64'(6));
    chk("ovr_done_cyc", 64'(done_cyc), 64'(9));
    tick();

    // bank select priority and empty select
    run_frame(4'b1010, 20, 3, 6);
    dv = q_bt_d[0];
    chk("bank_1010", 64'(dv[49:48]), 64'(1));
    run_frame(4'b0000, 30, 2, 5);
    dv = q_bt_d[1];
    chk("bank_0000", 64'(dv[49:48]), 64'(0));

    // reset while the third beat is stalled
    tready = 1'b1;
    launch(4'b0010, 50, 8);
    for (int n = 0; n < 50; n++) begin
      if (accepted >= 2) break;
      tick();
    end
    chk("mid_two_beats", 64'(accepted), 64'(2));
    tready = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("mid_rst_ctl", 64'({rd_en, rd_addr, tvalid, tuser,
        tlast, busy, done, overrun}), 64'(0));
    chk("mid_rst_tdata", 64'(tdata), 64'(0));
    exp_beat.delete();
    exp_addr.delete();
    tick();
    tick();
    reset  = 1'b0;
    tready = 1'b1;
    run_frame(4'b0010, 60, 2, 5);
    chk("post_rst_u0", 64'(q_bt_u[0]), 64'(1));
    chk("post_rst_l1", 64'(q_bt_l[1]), 64'(1));
    lit = {1'b0, 2'd1, 36'd0, 12'd60};
    chk("post_rst_d0", 64'(q_bt_d[0]), 64'(lit));

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
